// File: rtl/ram_wr_buffer.sv
// Write buffer between the RAM chip-select decoder and the shared port-B arbiter.
// Optional macro RAM_WR_CS_CHECK_EN rejects non-one-hot chip selects and adds cs_err.
module ram_wr_buffer #(
  parameter int DEPTH = 8,
  parameter int LVL_W = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr,
  input  logic [15:0]          ram_cs,
  input  logic [12:0]          Ram_Addr,
  input  logic signed [31:0]   Data,
  input  logic                 clear,
  input  logic                 mem_gnt,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [15:0]          mem_cs,
  output logic [12:0]          mem_addr,
  output logic signed [31:0]   mem_din,
  output logic [LVL_W-1:0]     fifo_level,
  output logic                 overflow,
  output logic [15:0]          wr_count,
  output logic [7:0]           drop_count
`ifdef RAM_WR_CS_CHECK_EN
  ,
  output logic                 cs_err
`endif
);

  localparam int CS_W   = 16;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int ENT_W  = CS_W + ADDR_W + DATA_W;
  localparam int PTR_W  = $clog2(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [1:0]              state, state_nxt;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [ENT_W-1:0]        fifo_mem [DEPTH];
  logic [ENT_W-1:0]        head;
  logic [LVL_W-1:0]        level_nxt;
  logic                    full, pop, cs_any, cs_ok, push, drop_full, drop;
  logic [CS_W-1:0]         cs_p1;
  logic [ADDR_W-1:0]       addr_p1;
  logic signed [DATA_W-1:0] din_p1;

  assign full   = (fifo_level == LVL_W'(DEPTH));
  assign pop    = (state == REQ) && mem_gnt;
  assign cs_any = |ram_cs;

`ifdef RAM_WR_CS_CHECK_EN
  logic cs_bad;
  assign cs_bad = wr && cs_any && ((ram_cs & (ram_cs - 16'd1)) != 16'd0);
  assign cs_ok  = !cs_bad;
`else
  assign cs_ok  = 1'b1;
`endif

  assign push      = wr && cs_any && cs_ok && (!full || pop);
  assign drop_full = wr && cs_any && cs_ok && full && !pop;
`ifdef RAM_WR_CS_CHECK_EN
  assign drop      = drop_full || cs_bad;
`else
  assign drop      = drop_full;
`endif

  always_comb begin
    level_nxt = fifo_level;
    if (push && !pop)
      level_nxt = fifo_level + LVL_W'(1);
    else if (pop && !push)
      level_nxt = fifo_level - LVL_W'(1);
  end

  // WRITE looks at the next level so a same-edge push keeps the port requested
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fifo_level != '0) state_nxt = REQ;
      REQ:     if (mem_gnt) state_nxt = WRITE;
      WRITE:   state_nxt = (level_nxt != '0) ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= {ram_cs, Ram_Addr, Data};
  end

  assign head = fifo_mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      addr_p1    <= '0;
    end else begin
      state      <= state_nxt;
      fifo_level <= level_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        addr_p1 <= head[DATA_W +: ADDR_W];
      end
    end
  end

  // Port-B stage: cs/data are zero-gated outside WRITE, so they need no reset
  always_ff @(posedge clk) begin
    if (pop) begin
      cs_p1  <= head[ENT_W-1 -: CS_W];
      din_p1 <= head[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      wr_count   <= '0;
      drop_count <= '0;
`ifdef RAM_WR_CS_CHECK_EN
      cs_err     <= 1'b0;
`endif
    end else if (clear) begin
      overflow   <= 1'b0;
      wr_count   <= '0;
      drop_count <= '0;
`ifdef RAM_WR_CS_CHECK_EN
      cs_err     <= 1'b0;
`endif
    end else begin
      if (push)      wr_count   <= wr_count + 16'd1;
      if (drop)      drop_count <= sat_inc8(drop_count);
      if (drop_full) overflow   <= 1'b1;
`ifdef RAM_WR_CS_CHECK_EN
      if (cs_bad)    cs_err     <= 1'b1;
`endif
    end
  end

  assign mem_req  = (state == REQ) || (state == WRITE);
  assign mem_we   = (state == WRITE);
  assign mem_cs   = mem_we ? cs_p1 : '0;
  assign mem_din  = mem_we ? din_p1 : '0;
  assign mem_addr = addr_p1;

endmodule

// File: tb/tb_ram_wr_buffer.sv
// Scoreboard bench for ram_wr_buffer: expected port-B writes are queued at push time
// and checked whenever mem_we is seen.
module tb_ram_wr_buffer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] ram_cs = '0;
  logic [12:0] Ram_Addr = '0;
  logic [31:0] Data = '0;
  logic        clear = 1'b0;
  logic        mem_gnt = 1'b0;
  logic        mem_req, mem_we;
  logic [15:0] mem_cs;
  logic [12:0] mem_addr;
  logic [31:0] mem_din;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic [15:0] wr_count;
  logic [7:0]  drop_count;
`ifdef RAM_WR_CS_CHECK_EN
  logic        cs_err;
`endif

  int total = 0;
  int bad = 0;
  int we_seen = 0;
  logic [60:0] sb[$];
  logic [60:0] exp_e;
  logic        prev_we = 1'b0;

  ram_wr_buffer #(.DEPTH(8), .LVL_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .wr(wr), .ram_cs(ram_cs), .Ram_Addr(Ram_Addr),
    .Data(Data), .clear(clear), .mem_gnt(mem_gnt), .mem_req(mem_req), .mem_we(mem_we),
    .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_din(mem_din), .fifo_level(fifo_level),
    .overflow(overflow), .wr_count(wr_count), .drop_count(drop_count)
`ifdef RAM_WR_CS_CHECK_EN
    , .cs_err(cs_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mem_we) begin
      we_seen++;
      total++;
      if (prev_we) begin
        bad++;
        $display("FAIL we_width got 2+ cycles want 1");
      end
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_we got cs=%h addr=%h din=%h want none", mem_cs, mem_addr, mem_din);
      end else begin
        exp_e = sb.pop_front();
        if ({mem_cs, mem_addr, mem_din} !== exp_e) begin
          bad++;
          $display("FAIL sb_entry got %h/%h/%h want %h/%h/%h", mem_cs, mem_addr, mem_din,
                   exp_e[60:45], exp_e[44:32], exp_e[31:0]);
        end
      end
    end
    prev_we = mem_we;
  end

  // Caller is at posedge+1; the strobe is sampled on the next posedge
  task automatic push(input logic [15:0] cs, input logic [12:0] a, input logic [31:0] d,
                      input bit accept);
    wr = 1'b1; ram_cs = cs; Ram_Addr = a; Data = d;
    if (accept) sb.push_back({cs, a, d});
    @(posedge clk); #1;
    wr = 1'b0; ram_cs = '0; Ram_Addr = '0; Data = '0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_drain got %0d pending want 0", nm, sb.size());
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({mem_req, mem_we, mem_cs, mem_addr, mem_din} !== '0) begin
      bad++;
      $display("FAIL reset_port got %b%b %h %h %h want zeros", mem_req, mem_we, mem_cs, mem_addr, mem_din);
    end
    total++;
    if ({fifo_level, overflow, wr_count, drop_count} !== '0) begin
      bad++;
      $display("FAIL reset_status got lvl=%0d ov=%b wc=%0d dc=%0d want 0", fifo_level, overflow, wr_count, drop_count);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    mem_gnt = 1'b1;
    push(16'h0004, 13'h0123, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    total++;
    if (mem_we !== 1'b0 || fifo_level !== 4'd1) begin
      bad++;
      $display("FAIL single_e0 got we=%b lvl=%0d want 0 1", mem_we, fifo_level);
    end
    @(negedge clk);
    total++;
    if (mem_we !== 1'b0 || mem_req !== 1'b1) begin
      bad++;
      $display("FAIL single_e1 got we=%b req=%b want 0 1", mem_we, mem_req);
    end
    @(negedge clk);
    total++;
    if (mem_we !== 1'b1 || mem_cs !== 16'h0004 || mem_addr !== 13'h0123 || mem_din !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL single_e2 got we=%b %h %h %h want 1 0004 0123 deadbeef", mem_we, mem_cs, mem_addr, mem_din);
    end
    @(negedge clk);
    total++;
    if (mem_we !== 1'b0 || fifo_level !== 4'd0 || wr_count !== 16'd1 || mem_cs !== 16'h0 ||
        mem_din !== 32'h0 || mem_addr !== 13'h0123) begin
      bad++;
      $display("FAIL single_after got we=%b lvl=%0d wc=%0d cs=%h din=%h addr=%h want 0 0 1 0 0 0123",
               mem_we, fifo_level, wr_count, mem_cs, mem_din, mem_addr);
    end
  endtask

  task automatic test_back_to_back();
    int cyc[$];
    int base;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    for (int i = 1; i <= 5; i++) push(16'(1) << i, 13'(i), 32'(i), 1'b1);
    base = we_seen;
    repeat (3) @(negedge clk);
    total++;
    if (fifo_level !== 4'd5 || mem_req !== 1'b1 || we_seen != base) begin
      bad++;
      $display("FAIL stall got lvl=%0d req=%b we_pulses=%0d want 5 1 0", fifo_level, mem_req, we_seen - base);
    end
    @(posedge clk); #1;
    mem_gnt = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (mem_we) cyc.push_back(i);
    end
    total++;
    if (cyc.size() != 5) begin
      bad++;
      $display("FAIL b2b_count got %0d want 5", cyc.size());
    end else begin
      for (int k = 1; k < 5; k++) begin
        total++;
        if (cyc[k] - cyc[k-1] != 2) begin
          bad++;
          $display("FAIL b2b_gap got %0d want 2", cyc[k] - cyc[k-1]);
        end
      end
    end
    drain("b2b");
  endtask

  task automatic test_overflow();
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    pulse_clear();
    for (int i = 0; i < 10; i++) push(16'h0100, 13'(16 + i), 32'h1000 + 32'(i), i < 8);
    @(negedge clk);
    total++;
    if (fifo_level !== 4'd8 || overflow !== 1'b1 || drop_count !== 8'd2 || wr_count !== 16'd8) begin
      bad++;
      $display("FAIL overflow got lvl=%0d ov=%b dc=%0d wc=%0d want 8 1 2 8", fifo_level, overflow, drop_count, wr_count);
    end
    @(posedge clk); #1;
    pulse_clear();
    total++;
    if (fifo_level !== 4'd8 || overflow !== 1'b0 || drop_count !== 8'd0 || wr_count !== 16'd0) begin
      bad++;
      $display("FAIL clear got lvl=%0d ov=%b dc=%0d wc=%0d want 8 0 0 0", fifo_level, overflow, drop_count, wr_count);
    end
  endtask

  task automatic test_full_pop();
    mem_gnt = 1'b1;
    push(16'h8000, 13'h1FFF, 32'hA5A5_5A5A, 1'b1);
    total++;
    if (fifo_level !== 4'd8 || overflow !== 1'b0 || wr_count !== 16'd1 || drop_count !== 8'd0 || mem_we !== 1'b1) begin
      bad++;
      $display("FAIL full_pop got lvl=%0d ov=%b wc=%0d dc=%0d we=%b want 8 0 1 0 1",
               fifo_level, overflow, wr_count, drop_count, mem_we);
    end
    drain("full_pop");
    repeat (2) @(negedge clk);
    total++;
    if (fifo_level !== 4'd0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL full_pop_empty got lvl=%0d req=%b want 0 0", fifo_level, mem_req);
    end
  endtask

  task automatic test_cs_zero();
    logic [15:0] wc;
    logic [7:0]  dc;
    @(posedge clk); #1;
    wc = wr_count;
    dc = drop_count;
    push(16'h0000, 13'h0AAA, 32'h1234_5678, 1'b0);
    repeat (4) @(negedge clk);
    total++;
    if (fifo_level !== 4'd0 || wr_count !== wc || drop_count !== dc || overflow !== 1'b0) begin
      bad++;
      $display("FAIL cs_zero got lvl=%0d wc=%0d dc=%0d ov=%b want 0 %0d %0d 0",
               fifo_level, wr_count, drop_count, overflow, wc, dc);
    end
  endtask

  task automatic test_cs_multi();
    logic [15:0] wc;
    logic [7:0]  dc;
    @(posedge clk); #1;
    wc = wr_count;
    dc = drop_count;
`ifdef RAM_WR_CS_CHECK_EN
    push(16'h0003, 13'h0055, 32'hFFFF_FFFE, 1'b0);
    repeat (4) @(negedge clk);
    total++;
    if (cs_err !== 1'b1 || drop_count !== dc + 8'd1 || wr_count !== wc || fifo_level !== 4'd0) begin
      bad++;
      $display("FAIL cs_multi got err=%b dc=%0d wc=%0d lvl=%0d want 1 %0d %0d 0",
               cs_err, drop_count, wr_count, fifo_level, dc + 8'd1, wc);
    end
`else
    push(16'h0003, 13'h0055, 32'hFFFF_FFFE, 1'b1);
    drain("cs_multi");
    total++;
    if (wr_count !== wc + 16'd1 || drop_count !== dc) begin
      bad++;
      $display("FAIL cs_multi got wc=%0d dc=%0d want %0d %0d", wr_count, drop_count, wc + 16'd1, dc);
    end
`endif
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    int base;
    mem_gnt = 1'b1;
    push(16'h0010, 13'h0001, 32'h0BAD_F00D, 1'b1);
    push(16'h0020, 13'h0002, 32'h0C0F_FEE0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (mem_we) begin
        found = 1'b1;
        break;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL reset_mid_find got no WRITE want WRITE");
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (mem_we !== 1'b0 || mem_req !== 1'b0 || mem_din !== 32'h0 || fifo_level !== 4'd0) begin
      bad++;
      $display("FAIL reset_mid got we=%b req=%b din=%h lvl=%0d want 0 0 0 0", mem_we, mem_req, mem_din, fifo_level);
    end
    sb.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    base = we_seen;
    repeat (10) @(negedge clk);
    total++;
    if (we_seen != base) begin
      bad++;
      $display("FAIL reset_mid_quiet got %0d pulses want 0", we_seen - base);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_cs_zero();
    test_cs_multi();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
